// File: rtl/alu_mult_seq.sv
// alu_mult_seq -- iterative 32x32 multiplier for MULT/MULTU into HI/LO.
//
// The block has no adder of its own. It drives the shared ALU from the
// initiator side and issues one ALU operation per cycle. Operand
// conditioning, 32 shift-add iterations and the final sign fix are
// sequenced by an internal FSM.
//
// Ports:
//   CLK        in   rising-edge system clock
//   nRST       in   synchronous active-low reset
//   start      in   request a multiply (sampled only in IDLE)
//   is_signed  in   1 = MULT (two's complement), 0 = MULTU
//   mcand      in   multiplicand (sampled with start)
//   mplier     in   multiplier   (sampled with start)
//   busy       out  high in every state except IDLE and DONE
//   done       out  one-cycle pulse, hi/lo valid
//   hi, lo     out  product bits [63:32] / [31:0], held until next start
//   aluop      out  operation requested from the ALU
//   port_a/b   out  ALU operands
//   alu_out    in   ALU result
//   alu_ovf    in   ALU carry-out (bit 32 of A+B for ALU_ADD)

package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;
endpackage

module alu_mult_seq
  import cpu_types_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   start,
  input  logic   is_signed,
  input  word_t  mcand,
  input  word_t  mplier,
  output logic   busy,
  output logic   done,
  output word_t  hi,
  output word_t  lo,
  output aluop_t aluop,
  output word_t  port_a,
  output word_t  port_b,
  input  word_t  alu_out,
  input  logic   alu_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  word_t      mc_q, mc_d;
  word_t      acc_q, acc_d;
  word_t      lo_q, lo_d;
  logic [5:0] cnt_q, cnt_d;
  logic       neg_q, neg_d;
  logic       z_q, z_d;

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    z_d     = z_q;
    aluop   = ALU_ADD;
    port_a  = '0;
    port_b  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_d  = mcand;
          lo_d  = mplier;
          acc_d = '0;
          cnt_d = '0;
          neg_d = is_signed & (mcand[31] ^ mplier[31]);
          if (is_signed && mcand[31])
            state_d = S_NEG_A;
          else if (is_signed && mplier[31])
            state_d = S_NEG_B;
          else
            state_d = S_ITER;
        end
      end

      S_NEG_A: begin
        aluop  = ALU_SUB;
        port_b = mc_q;
        mc_d   = alu_out;
        // NEG_A is only reachable for a signed op and lo still holds the
        // raw multiplier, so its sign bit decides whether NEG_B follows.
        state_d = lo_q[31] ? S_NEG_B : S_ITER;
      end

      S_NEG_B: begin
        aluop   = ALU_SUB;
        port_b  = lo_q;
        lo_d    = alu_out;
        state_d = S_ITER;
      end

      S_ITER: begin
        port_a = acc_q;
        port_b = lo_q[0] ? mc_q : '0;
        // Right shift of {carry, sum, lo}: the multiplier bits drain out of
        // lo while the low product bits shift in from the sum.
        {acc_d, lo_d} = {alu_ovf, alu_out, lo_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31)
          state_d = neg_q ? S_FIX_LO : S_DONE;
      end

      S_FIX_LO: begin
        aluop   = ALU_SUB;
        port_b  = lo_q;
        lo_d    = alu_out;
        z_d     = (lo_q == '0);
        state_d = S_FIX_HI;
      end

      S_FIX_HI: begin
        // 64-bit negate: hi = ~hi + borrow-free flag from the low half.
        port_a  = ~acc_q;
        port_b  = {31'b0, z_q};
        acc_d   = alu_out;
        state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      mc_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign hi   = acc_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq. Provides a behavioural ALU and
// compares product, latency and busy/done behaviour against a reference
// computed with native 64-bit arithmetic.

module tb_alu_mult_seq;
  import cpu_types_pkg::*;

  logic   CLK = 1'b0;
  logic   nRST;
  logic   start;
  logic   is_signed;
  word_t  mcand, mplier;
  logic   busy, done;
  word_t  hi, lo;
  aluop_t aluop;
  word_t  port_a, port_b;
  word_t  alu_out;
  logic   alu_ovf;

  int vectors = 0;
  int miscompares = 0;

  word_t last_hi, last_lo;

  alu_mult_seq dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (start),
    .is_signed(is_signed),
    .mcand    (mcand),
    .mplier   (mplier),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .aluop    (aluop),
    .port_a   (port_a),
    .port_b   (port_b),
    .alu_out  (alu_out),
    .alu_ovf  (alu_ovf)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU on the target side of the interface.
  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (aluop)
      ALU_ADD: {alu_ovf, alu_out} = {1'b0, port_a} + {1'b0, port_b};
      ALU_SUB: alu_out = port_a - port_b;
      ALU_AND: alu_out = port_a & port_b;
      ALU_OR:  alu_out = port_a | port_b;
      default: alu_out = '0;
    endcase
  end

  function automatic logic [63:0] ref_product(input word_t a, input word_t b,
                                              input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int ref_latency(input word_t a, input word_t b,
                                     input logic s);
    if (s && a[31] && b[31]) return 35;
    if (s && (a[31] ^ b[31])) return 36;
    return 33;
  endfunction

  // Runs one multiply starting in the next cycle (which must be IDLE).
  // With pulse_start set, stray starts are raised at cycles 5 and 20.
  task automatic run_op(input string name, input word_t a, input word_t b,
                        input logic s, input bit pulse_start);
    logic [63:0] exp_p;
    int exp_lat;
    int lat;
    int trace_err;
    exp_p   = ref_product(a, b, s);
    exp_lat = ref_latency(a, b, s);
    lat     = -1;
    trace_err = 0;

    @(posedge CLK); #1;
    start = 1'b1; is_signed = s; mcand = a; mplier = b;
    @(posedge CLK); #1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      start     = pulse_start && (cyc == 5 || cyc == 20);
      is_signed = $urandom_range(0, 1);
      mcand     = $urandom;
      mplier    = $urandom;
      if (busy !== (cyc < exp_lat) || done !== (cyc == exp_lat))
        trace_err++;
      if (busy === 1'b1 && done === 1'b1) trace_err++;
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;

    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    vectors++;
    if (hi !== exp_p[63:32]) begin
      miscompares++;
      $display("FAIL %s hi: got %h expected %h", name, hi, exp_p[63:32]);
    end
    vectors++;
    if (lo !== exp_p[31:0]) begin
      miscompares++;
      $display("FAIL %s lo: got %h expected %h", name, lo, exp_p[31:0]);
    end
    vectors++;
    if (trace_err != 0) begin
      miscompares++;
      $display("FAIL %s busy/done trace: got %0d bad cycles expected 0",
               name, trace_err);
    end
    last_hi = exp_p[63:32];
    last_lo = exp_p[31:0];
  endtask

  task automatic test_reset();
    nRST = 1'b0; start = 1'b0; is_signed = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
               busy, done, hi, lo);
    end
    vectors++;
    if (aluop !== ALU_ADD || port_a !== '0 || port_b !== '0) begin
      miscompares++;
      $display("FAIL reset alu drive: got op=%0d a=%h b=%h expected op=%0d a=0 b=0",
               aluop, port_a, port_b, ALU_ADD);
    end
    nRST = 1'b1;
  endtask

  task automatic test_directed();
    run_op("u_3x5",      32'd3,        32'd5,        1'b0, 1'b0);
    run_op("u_max",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("s_m3x5",     32'hFFFFFFFD, 32'd5,        1'b1, 1'b0);
    run_op("s_m1xm1",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("s_minxmin",  32'h80000000, 32'h80000000, 1'b1, 1'b0);
    run_op("s_minx1",    32'h80000000, 32'd1,        1'b1, 1'b0);
    run_op("s_5xm3",     32'd5,        32'hFFFFFFFD, 1'b1, 1'b0);
    run_op("u_zero",     32'd0,        32'h12345678, 1'b0, 1'b0);
    run_op("s_zeroxneg", 32'd0,        32'hFFFFFFF0, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    int err;
    err = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (hi !== last_hi || lo !== last_lo || busy !== 1'b0 || done !== 1'b0)
        err++;
    end
    vectors++;
    if (err != 0) begin
      miscompares++;
      $display("FAIL idle hold: got %0d bad cycles (hi=%h lo=%h) expected 0",
               err, hi, lo);
    end
  endtask

  task automatic test_ignored_start();
    run_op("stray_start", 32'h0001_2345, 32'h0000_6789, 1'b0, 1'b1);
    run_op("back_to_back", 32'hDEADBEEF, 32'h00C0FFEE, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    word_t a, b;
    logic  s;
    word_t specials [4];
    specials[0] = 32'h80000000;
    specials[1] = 32'hFFFFFFFF;
    specials[2] = 32'h00000000;
    specials[3] = 32'h7FFFFFFF;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = specials[$urandom_range(0, 3)];
      if (i % 6 == 1) b = specials[$urandom_range(0, 3)];
      s = $urandom_range(0, 1);
      run_op($sformatf("rand%0d", i), a, b, s, 1'b0);
    end
  endtask

  task automatic test_abort();
    int saw_done;
    saw_done = 0;
    @(posedge CLK); #1;
    start = 1'b1; is_signed = 1'b1; mcand = 32'hFFFFFFFD; mplier = 32'd7;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (done === 1'b1) saw_done++;
      @(posedge CLK); #1;
    end
    nRST = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL abort reset: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
               busy, done, hi, lo);
    end
    nRST = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done++;
      @(posedge CLK); #1;
    end
    vectors++;
    if (saw_done != 0) begin
      miscompares++;
      $display("FAIL abort no_done: got %0d active cycles expected 0", saw_done);
    end
    last_hi = '0;
    last_lo = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_ignored_start();
    test_random();
    test_abort();
    run_op("after_abort", 32'd12, 32'd11, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
